muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide unit for the five-stage MIPS pipeline. It owns the HI/LO register pair and runs signed/unsigned 32-bit multiplies and divides iteratively, one bit per cycle, started by the execute-stage muldiv control signal. While an operation is running it raises a decode-stage stall for any instruction that needs HI/LO or the unit itself. The hazard unit ORs this stall into its existing stall/flush logic.

---
 rtl/muldiv_sequencer_if.sv | 39 +++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
// Bundles the pipeline-side signals of the multiply/divide sequencer.
//   master : pipeline side, drives the execute-stage start/op/operands and
//            the decode-stage HI/LO demand, observes busy/stall/results.
//   slave  : the sequencer itself.
// Signals:
//   startE    execute stage holds mult/multu/div/divu
//   opE       00 mult, 01 multu, 10 div, 11 divu
//   srcaE     rs operand (multiplicand / dividend)
//   srcbE     rt operand (multiplier / divisor)
//   needhiloD decode holds mfhi, mflo or a muldiv instruction
//   busy      operation in progress
//   stallD    decode stall request to the hazard unit
//   hi, lo    HI/LO architectural registers
//   divzero   sticky flag: last divide had a zero divisor
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             needhiloD;
  logic             busy;
  logic             stallD;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output startE, opE, srcaE, srcbE, needhiloD,
    input  busy, stallD, hi, lo, divzero
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, needhiloD,
    output busy, stallD, hi, lo, divzero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative signed/unsigned multiply and divide unit owning the HI/LO pair.
// One bit is processed per cycle over WIDTH cycles on operand magnitudes;
// signs are applied in a final FIX cycle that also writes HI/LO.
// Ports:
//   clk    pipeline clock, rising edge
//   reset  synchronous, active-high; clears state, HI, LO and divzero
//   bus    muldiv_sequencer_if.slave (start/op/operands, needhiloD in;
//          busy, stallD, hi, lo, divzero out)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc_hi holds P (multiply) or R (divide); acc_lo holds M or Q.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // Multiplicand magnitude for multiplies, divisor magnitude for divides.
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             divzero_q, divzero_d;

  // Datapath intermediates
  logic             signed_op;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [2*WIDTH-1:0] product;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      operand_q <= operand_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divzero_q <= divzero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    operand_d = operand_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divzero_d = divzero_q;

    // opE[0]=0 selects the signed variants. The most negative value maps to
    // its own bit pattern, which read unsigned is the correct magnitude.
    signed_op = ~bus.opE[0];
    sign_a    = signed_op & bus.srcaE[WIDTH-1];
    sign_b    = signed_op & bus.srcbE[WIDTH-1];
    mag_a     = sign_a ? (~bus.srcaE + WIDTH'(1)) : bus.srcaE;
    mag_b     = sign_b ? (~bus.srcbE + WIDTH'(1)) : bus.srcbE;

    // Shift-add step: carry out of P becomes the new top bit of P.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : '0);

    // Restoring step: the shifted remainder needs one extra bit, and the
    // subtraction one more for the borrow.
    rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, operand_q};
    borrow    = trial[WIDTH+1];

    product   = {acc_hi_q, acc_lo_q};
    if (neg_lo_q) begin
      product = ~product + (2*WIDTH)'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.startE) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = bus.opE[1];
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = bus.opE[1] ? sign_a : (sign_a ^ sign_b);
          acc_hi_d = '0;
          if (bus.opE[1]) begin
            acc_lo_d  = mag_a;
            operand_d = mag_b;
          end else begin
            acc_lo_d  = mag_b;
            operand_d = mag_a;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_hi_d = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~borrow};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        if (is_div_q) begin
          // A zero divisor leaves the raw all-ones quotient and the dividend
          // magnitude in place, with no sign correction.
          if (operand_q == '0) begin
            lo_d      = acc_lo_q;
            hi_d      = acc_hi_q;
            divzero_d = 1'b1;
          end else begin
            lo_d      = neg_lo_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
            hi_d      = neg_hi_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
            divzero_d = 1'b0;
          end
        end else begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.stallD  = bus.busy & bus.needhiloD;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// random operations compared against an arithmetic reference model.
module tb_muldiv_sequencer;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus();

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;
  logic        expDz = 1'b0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Architectural result of one operation, from plain arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] rh,
                                   output logic [31:0] rl, inout logic dz);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic        sa, sb;
    sa = (op[0] == 1'b0) && a[31];
    sb = (op[0] == 1'b0) && b[31];
    ma = sa ? (32'd0 - a) : a;
    mb = sb ? (32'd0 - b) : b;
    if (op[1] == 1'b0) begin
      if (op[0] == 1'b0)
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else
        p = {32'd0, a} * {32'd0, b};
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 32'd0) begin
      rl = 32'hFFFF_FFFF;
      rh = ma;
      dz = 1'b1;
    end else begin
      q  = ma / mb;
      r  = ma % mb;
      rl = (sa ^ sb) ? (32'd0 - q) : q;
      rh = sa ? (32'd0 - r) : r;
      dz = 1'b0;
    end
  endfunction

  // Runs one operation. stallAt/restartAt/resetAt name the edge index
  // (1 = first edge after the start edge) at which the decode demand is
  // raised, a second start is pulsed, or reset is asserted; 0 disables.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int stallAt,
                               input int restartAt, input int resetAt);
    logic [31:0] nh, nl;
    logic        nd;
    int          cycles, stallCount;
    bit          done;
    nd = expDz;
    refModel(op, a, b, nh, nl, nd);
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    bus.startE = 1'b1;
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    checkOutput("busy_after_start", {63'd0, bus.busy}, 64'd1);
    cycles     = 0;
    stallCount = 0;
    done       = 1'b0;
    for (int e = 1; e <= 45 && !done; e++) begin
      if (e == stallAt) bus.needhiloD = 1'b1;
      if (e == restartAt) begin
        bus.startE = 1'b1;
        bus.opE    = 2'($urandom);
        bus.srcaE  = $urandom;
        bus.srcbE  = $urandom;
      end
      if (e == resetAt) reset = 1'b1;
      #1;
      if (bus.stallD) stallCount++;
      @(posedge clk);
      #1;
      bus.startE = 1'b0;
      if (e == resetAt) begin
        reset = 1'b0;
        checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("reset_stall", {63'd0, bus.stallD}, 64'd0);
        checkOutput("reset_hi", {32'd0, bus.hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, bus.lo}, 64'd0);
        checkOutput("reset_divzero", {63'd0, bus.divzero}, 64'd0);
        expHi = '0;
        expLo = '0;
        expDz = 1'b0;
        bus.needhiloD = 1'b0;
        return;
      end
      if (e == 20) begin
        checkOutput("hi_held", {32'd0, bus.hi}, {32'd0, expHi});
        checkOutput("lo_held", {32'd0, bus.lo}, {32'd0, expLo});
      end
      if (!bus.busy) begin
        cycles = e;
        done   = 1'b1;
      end
    end
    checkOutput("busy_cycles", 64'(cycles), 64'd33);
    if (stallAt > 0) begin
      checkOutput("stall_cycles", 64'(stallCount), 64'(34 - stallAt));
      checkOutput("stall_released", {63'd0, bus.stallD}, 64'd0);
    end
    checkOutput("hi", {32'd0, bus.hi}, {32'd0, nh});
    checkOutput("lo", {32'd0, bus.lo}, {32'd0, nl});
    checkOutput("divzero", {63'd0, bus.divzero}, {63'd0, nd});
    expHi = nh;
    expLo = nl;
    expDz = nd;
    bus.needhiloD = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset         = 1'b1;
    bus.startE    = 1'b0;
    bus.opE       = 2'b00;
    bus.srcaE     = '0;
    bus.srcbE     = '0;
    bus.needhiloD = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_busy", {63'd0, bus.busy}, 64'd0);
    checkOutput("init_stall", {63'd0, bus.stallD}, 64'd0);
    checkOutput("init_hi", {32'd0, bus.hi}, 64'd0);
    checkOutput("init_lo", {32'd0, bus.lo}, 64'd0);
    checkOutput("init_divzero", {63'd0, bus.divzero}, 64'd0);

    // Start coinciding with reset must not launch an operation.
    bus.startE = 1'b1;
    bus.opE    = 2'b01;
    bus.srcaE  = 32'd7;
    bus.srcbE  = 32'd9;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.startE    = 1'b0;
    bus.needhiloD = 1'b0;
    checkOutput("start_under_reset", {63'd0, bus.busy}, 64'd0);

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    applyStimulus(2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 0, 0, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0);
    applyStimulus(2'b11, 32'd100, 32'd0, 0, 0, 0);
    applyStimulus(2'b11, 32'd9, 32'd4, 0, 0, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    applyStimulus(2'b00, 32'h1234_5678, 32'h8765_4321, 3, 10, 0);
    bus.needhiloD = 1'b1;
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 16);
    applyStimulus(2'b01, 32'd3, 32'd5, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 1000);
        2:       rb = 32'd0 - $urandom_range(1, 1000);
        default: rb = $urandom;
      endcase
      applyStimulus(rop, ra, rb, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
